// File: rtl/sdr_dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sdr_dsp_pkg
//  Brief   : Shared CIC constants, FSM state type and small helper functions
//  Revision: 1.0 - initial release
// ============================================================================
package sdr_dsp_pkg;

  localparam int CIC_IN_WIDTH  = 32;
  localparam int CIC_N_STAGES  = 3;
  localparam int CIC_LOG2_RMAX = 6;
  localparam int CIC_ACC_WIDTH = CIC_IN_WIDTH + CIC_N_STAGES * CIC_LOG2_RMAX;

  localparam int DEC_LOG2_W   = 3;
  localparam int DEC_LOG2_MIN = 2;
  localparam int DEC_LOG2_MAX = CIC_LOG2_RMAX;

  typedef enum logic [0:0] {
    CIC_IDLE = 1'b0,
    CIC_RUN  = 1'b1
  } cic_state_e;

  // Sign-extend one input sample to the accumulator width.
  function automatic logic [CIC_ACC_WIDTH-1:0] sext_acc(input logic [CIC_IN_WIDTH-1:0] v);
    return {{(CIC_ACC_WIDTH - CIC_IN_WIDTH){v[CIC_IN_WIDTH-1]}}, v};
  endfunction

  // Clamp a requested log2 ratio into [DEC_LOG2_MIN, vmax].
  function automatic logic [DEC_LOG2_W-1:0] clamp_log2(input logic [DEC_LOG2_W-1:0] v,
                                                        input logic [DEC_LOG2_W-1:0] vmax);
    if (v < DEC_LOG2_W'(DEC_LOG2_MIN)) return DEC_LOG2_W'(DEC_LOG2_MIN);
    if (v > vmax) return vmax;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_decimator_if.sv
`default_nettype none
// ============================================================================
//  Module  : cic_decimator_if
//  Brief   : I/Q sample stream into and decimated I/Q stream out of the CIC
//  Revision: 1.0 - initial release
// ============================================================================
interface cic_decimator_if
  import sdr_dsp_pkg::*;
#(
  parameter int IN_WIDTH  = CIC_IN_WIDTH,
  parameter int OUT_WIDTH = 32
);
  logic [IN_WIDTH-1:0]  in_i;
  logic [IN_WIDTH-1:0]  in_q;
  logic                 in_valid;
  logic [OUT_WIDTH-1:0] out_i;
  logic [OUT_WIDTH-1:0] out_q;
  logic                 out_valid;

  // Sample source / result sink (e.g. DDC side plus downstream consumer)
  modport master (output in_i, in_q, in_valid, input out_i, out_q, out_valid);
  // The decimator itself
  modport slave  (input in_i, in_q, in_valid, output out_i, out_q, out_valid);
endinterface
`default_nettype wire

// File: rtl/cic_channel.sv
`default_nettype none
// ============================================================================
//  Module  : cic_channel
//  Brief   : Single-channel CIC datapath: integrator cascade, comb pipeline
//            and scaled output register. Control comes from the parent.
//  Revision: 1.0 - initial release
// ============================================================================
module cic_channel
  import sdr_dsp_pkg::*;
#(
  parameter int IN_WIDTH  = CIC_IN_WIDTH,
  parameter int OUT_WIDTH = 32,
  parameter int N_STAGES  = CIC_N_STAGES,
  parameter int ACC_WIDTH = CIC_ACC_WIDTH,
  parameter int SHIFT_W   = 5
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 flush,
  input  wire logic                 int_en,
  input  wire logic [N_STAGES-1:0]  comb_en,
  input  wire logic                 out_en,
  input  wire logic [SHIFT_W-1:0]   shift,
  input  wire logic [IN_WIDTH-1:0]  x,
  output logic      [OUT_WIDTH-1:0] y
);

  logic        [ACC_WIDTH-1:0] int_q   [N_STAGES];
  logic        [ACC_WIDTH-1:0] int_d   [N_STAGES];
  logic        [ACC_WIDTH-1:0] dly_q   [N_STAGES];
  logic        [ACC_WIDTH-1:0] dly_d   [N_STAGES];
  logic        [ACC_WIDTH-1:0] comb_q  [N_STAGES];
  logic        [ACC_WIDTH-1:0] comb_d  [N_STAGES];
  logic        [ACC_WIDTH-1:0] comb_in [N_STAGES];
  logic        [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic        [OUT_WIDTH-1:0] y_q;
  logic        [OUT_WIDTH-1:0] y_d;

  assign x_ext      = sext_acc(x);
  assign comb_in[0] = int_q[N_STAGES-1];

  // Each comb stage after the first is fed by the previous comb output.
  for (genvar k = 1; k < N_STAGES; k++) begin : g_comb_link
    assign comb_in[k] = comb_q[k-1];
  end

  // Arithmetic shift removes the R^N gain; floor truncation, no rounding.
  assign shifted = $signed(comb_q[N_STAGES-1]) >>> shift;

  // Integrator cascade; each stage adds the previous stage's old value, wraps freely.
  always_comb begin
    for (int k = 0; k < N_STAGES; k++) int_d[k] = int_q[k];
    if (flush) begin
      for (int k = 0; k < N_STAGES; k++) int_d[k] = '0;
    end else if (int_en) begin
      int_d[0] = int_q[0] + x_ext;
      for (int k = 1; k < N_STAGES; k++) int_d[k] = int_q[k] + int_q[k-1];
    end
  end

  // Comb stages advance individually with their valid; delays clear on flush.
  always_comb begin
    for (int k = 0; k < N_STAGES; k++) begin
      dly_d[k]  = dly_q[k];
      comb_d[k] = comb_q[k];
      if (flush) begin
        dly_d[k] = '0;
      end else if (comb_en[k]) begin
        comb_d[k] = comb_in[k] - dly_q[k];
        dly_d[k]  = comb_in[k];
      end
    end
  end

  // Output register holds its value between strobes.
  always_comb begin
    y_d = out_en ? shifted[OUT_WIDTH-1:0] : y_q;
  end

  // State registers for the whole channel datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) begin
        int_q[k]  <= '0;
        dly_q[k]  <= '0;
        comb_q[k] <= '0;
      end
      y_q <= '0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        int_q[k]  <= int_d[k];
        dly_q[k]  <= dly_d[k];
        comb_q[k] <= comb_d[k];
      end
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule
`default_nettype wire

// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
//  Module  : cic_decimator
//  Brief   : Dual-channel (I/Q) N-stage CIC decimator with run/flush control,
//            runtime power-of-two ratio and sticky configuration error.
//  Revision: 1.0 - initial release
// ============================================================================
module cic_decimator
  import sdr_dsp_pkg::*;
#(
  parameter int IN_WIDTH  = CIC_IN_WIDTH,
  parameter int OUT_WIDTH = 32,
  parameter int N_STAGES  = CIC_N_STAGES,
  parameter int LOG2_RMAX = CIC_LOG2_RMAX,
  parameter int ACC_WIDTH = IN_WIDTH + N_STAGES * LOG2_RMAX
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  enable,
  input  wire logic [DEC_LOG2_W-1:0] dec_log2,
  cic_decimator_if.slave             bus,
  output logic                       cfg_err
);

  localparam int SHIFT_W = $clog2(N_STAGES * LOG2_RMAX + 1);

  cic_state_e            state_q, state_d;
  logic [DEC_LOG2_W-1:0] r_log2_q, r_log2_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [LOG2_RMAX-1:0]  cnt_q, cnt_d;
  logic                  s0_q, s0_d;
  logic [N_STAGES-1:0]   vld_q, vld_d;
  logic                  out_valid_q, out_valid_d;

  logic                  run;
  logic                  flush;
  logic                  accept;
  logic                  cnt_last;
  logic [N_STAGES-1:0]   comb_en;
  logic                  out_en;
  logic [SHIFT_W-1:0]    shift;

  assign run      = (state_q == CIC_RUN) && enable;
  assign flush    = (state_q == CIC_RUN) && !enable;
  assign accept   = run && bus.in_valid;
  assign cnt_last = (cnt_q == LOG2_RMAX'((1 << r_log2_q) - 1));
  // Stage k fires on the valid that stage k-1 produced last cycle; s0 feeds stage 0.
  assign comb_en  = {vld_q[N_STAGES-2:0], s0_q} & {N_STAGES{run}};
  assign out_en   = vld_q[N_STAGES-1] & run;
  assign shift    = SHIFT_W'(N_STAGES * int'(r_log2_q));

  // Run/flush FSM, decimation counter and shared valid pipeline.
  always_comb begin
    state_d     = state_q;
    r_log2_d    = r_log2_q;
    cfg_err_d   = cfg_err_q;
    cnt_d       = cnt_q;
    s0_d        = 1'b0;
    vld_d       = '0;
    out_valid_d = 1'b0;
    case (state_q)
      CIC_IDLE: begin
        if (enable) begin
          state_d  = CIC_RUN;
          r_log2_d = clamp_log2(dec_log2, DEC_LOG2_W'(LOG2_RMAX));
          if (r_log2_d != dec_log2) cfg_err_d = 1'b1;
        end
      end
      CIC_RUN: begin
        if (!enable) begin
          state_d = CIC_IDLE;
          cnt_d   = '0;
        end else begin
          if (accept) begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
            s0_d  = cnt_last;
          end
          vld_d       = comb_en;
          out_valid_d = out_en;
        end
      end
      default: state_d = CIC_IDLE;
    endcase
  end

  // Control registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CIC_IDLE;
      r_log2_q    <= '0;
      cfg_err_q   <= 1'b0;
      cnt_q       <= '0;
      s0_q        <= 1'b0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_log2_q    <= r_log2_d;
      cfg_err_q   <= cfg_err_d;
      cnt_q       <= cnt_d;
      s0_q        <= s0_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
    end
  end

  cic_channel #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .N_STAGES (N_STAGES),
    .ACC_WIDTH(ACC_WIDTH),
    .SHIFT_W  (SHIFT_W)
  ) u_chan_i (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .int_en (accept),
    .comb_en(comb_en),
    .out_en (out_en),
    .shift  (shift),
    .x      (bus.in_i),
    .y      (bus.out_i)
  );

  cic_channel #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .N_STAGES (N_STAGES),
    .ACC_WIDTH(ACC_WIDTH),
    .SHIFT_W  (SHIFT_W)
  ) u_chan_q (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .int_en (accept),
    .comb_en(comb_en),
    .out_en (out_en),
    .shift  (shift),
    .x      (bus.in_q),
    .y      (bus.out_q)
  );

  assign bus.out_valid = out_valid_q;
  assign cfg_err       = cfg_err_q;

endmodule
`default_nettype wire

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Dual-channel (I/Q) N-stage cascaded integrator-comb decimator, placed directly downstream of digital_downconverter.
- Consumes i_component/q_component/ddc_valid at the DDC rate and emits baseband I/Q at 1/R of that rate.
- Unity DC gain for power-of-two ratios.
- Feeds the channel filter / FFT buffer stages.

Parameters:
- IN_WIDTH, 32, input sample width (two's complement).
- OUT_WIDTH, 32, output sample width; must be ≤ IN_WIDTH.
- N_STAGES, 3, number of integrator and comb stages.
- LOG2_RMAX, 6, log2 of maximum decimation ratio (Rmax = 64).
- ACC_WIDTH, IN_WIDTH+N_STAGES*LOG2_RMAX (50), internal accumulator width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run control; low = flush and hold.
- dec_log2  in  3  log2(R); legal range 2..LOG2_RMAX.
- in_i  in  IN_WIDTH  I sample (from DDC i_component).
- in_q  in  IN_WIDTH  Q sample (from DDC q_component).
- in_valid  in  1  input qualifier (from ddc_valid).
- out_i  out  OUT_WIDTH  decimated I.
- out_q  out  OUT_WIDTH  decimated Q.
- out_valid  out  1  one-cycle strobe per output sample.
- cfg_err  out  1  sticky; set when latched dec_log2 was out of range.

Behaviour:
- Reset (rst=1 at a clk edge) clears all of the following to 0: integrators, comb delays, comb pipeline, decimation counter, latched ratio, out_i, out_q, out_valid and cfg_err. Reset takes priority over every other event, including mid-period and mid-pipeline.
- States: IDLE and RUN.
  - IDLE→RUN on the first edge with enable=1. On that edge dec_log2 is latched to r_log2, clamped to [2, LOG2_RMAX]. If clamping occurs, cfg_err is set.
  - RUN→IDLE on any edge with enable=0. This clears integrators, comb delays, the counter and the pipeline valids. In-flight outputs are discarded.
  - dec_log2 changes while in RUN are ignored until the next IDLE→RUN.
- Integrators (RUN, in_valid=1 only):
  - int1 += sign-extended x.
  - int_k += int_(k-1) (previous-cycle value) for k = 2..N.
  - Arithmetic is modulo 2^ACC_WIDTH; wrap-around is required and must not be saturated.
- Decimation counter:
  - Increments on each accepted input and wraps at R-1, where R = 2^r_log2.
  - On the wrap edge, registered strobe s0 is set for one cycle.
  - The first output corresponds to the R-th accepted input after entering RUN.
- Comb pipeline:
  - One stage per cycle, each advancing only with its valid bit.
  - c1 = int_N − d1; c_k = c_(k-1) − d_k; each d_k is updated with its stage input.
  - Arithmetic is modulo 2^ACC_WIDTH.
- Output register:
  - out = (c_N >>> (N_STAGES*r_log2))[OUT_WIDTH-1:0], arithmetic shift (floor truncation, no rounding).
  - I and Q use identical paths and are always co-valid.
- Latency: out_valid is high in the cycle following the 4th edge after the edge accepting the decimating input (for N=3).
- out_i/out_q hold their value between strobes.
- in_valid may be asserted every cycle. No backpressure exists; downstream must accept every out_valid.
- in_valid while in IDLE is ignored.

Decomposition:
- Shared package sdr_dsp_pkg holds:
  - CIC constants (N_STAGES, LOG2_RMAX, ACC_WIDTH).
  - Legal dec_log2 min/max.
  - Sign-extend helper function.
- One natural sub-module: cic_channel, the single-channel integrator/comb datapath, instantiated twice (I and Q).
- The counter, FSM and valid pipeline live in the top module and are shared by both channels.

Test Plan:
- DC: enable, dec_log2=3, continuous in_valid, in_i=0x00001000, in_q=0xFFFFF000 → after the first 3 outputs, every out_i=0x00001000 and out_q=0xFFFFF000; out_valid every 8 cycles.
- Impulse: dec_log2=2, in_i=0x00004000 for one sample, then zeros → out_i values are all non-negative multiples of 0x100, at most 4 non-zero, and sum to 0x00001000; out_q stays 0.
- Rate/latency: dec_log2=2, in_valid continuous → first out_valid exactly 4 cycles after the 4th accepted edge, then exactly one strobe every 4 cycles. Repeat with in_valid 1-in-3 → strobe every 12 cycles.
- Config: dec_log2=7 then enable → cfg_err=1 and R=64 (strobe every 64 inputs). Change dec_log2 to 2 while in RUN → period unchanged. Drop enable for one cycle, then raise it → period becomes 4, with no stale out_valid in between.
- Wrap: full-scale input 0x7FFFFFFF, dec_log2=6, for 2000 inputs → steady-state out_i=0x7FFFFFFF with no corruption despite integrator overflow.
- Reset mid-run: assert rst two cycles after a decimating input → out_valid stays 0, outputs=0, cfg_err=0. The next run's first output lands after R inputs with DC-correct value.
